// File: rtl/fifo_rr_scheduler_pkg.sv
// fifo_rr_scheduler_pkg: shared FSM state encodings and default sizes for the FIFO bank and its scheduler.
package fifo_rr_scheduler_pkg;
   localparam int NUM_FIFOS_DEF  = 4;
   localparam int DATA_WIDTH_DEF = 10;
   localparam int SEL_WIDTH_DEF  = 2;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      PAUSE  = 2'd2,
      ERROR  = 2'd3
   } state_t;
endpackage

// File: rtl/fifo_rr_scheduler_if.sv
// fifo_rr_scheduler_if: source-FIFO bank and downstream stream signals of the scheduler.
// master: the scheduler (drives fifo_pop and the output stream).
// slave: the FIFO bank / downstream side (drives empty, error, data, almost_full).
interface fifo_rr_scheduler_if
   import fifo_rr_scheduler_pkg::*;
#(
   parameter int NUM_FIFOS  = NUM_FIFOS_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int SEL_WIDTH  = SEL_WIDTH_DEF
);
   logic [NUM_FIFOS-1:0]            fifo_empty;
   logic [NUM_FIFOS-1:0]            fifo_error;
   logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_data;
   logic [NUM_FIFOS-1:0]            fifo_pop;
   logic                            down_almost_full;
   logic [DATA_WIDTH-1:0]           out_data;
   logic                            out_valid;
   logic [SEL_WIDTH-1:0]            out_sel;
   modport master (
      input  fifo_empty, fifo_error, fifo_data, down_almost_full,
      output fifo_pop, out_data, out_valid, out_sel
   );
   modport slave (
      output fifo_empty, fifo_error, fifo_data, down_almost_full,
      input  fifo_pop, out_data, out_valid, out_sel
   );
endinterface

// File: rtl/fifo_rr_scheduler_rr_pick.sv
// rr_pick: combinational round-robin picker; first requester after `last` wins.
// req: request vector; last: previously served index.
// gnt_valid: some request found; gnt_idx: winning index (holds `last` when none).
module rr_pick
   import fifo_rr_scheduler_pkg::*;
#(
   parameter int NUM_FIFOS = NUM_FIFOS_DEF,
   parameter int SEL_WIDTH = SEL_WIDTH_DEF
) (
   input  logic [NUM_FIFOS-1:0] req,
   input  logic [SEL_WIDTH-1:0] last,
   output logic                 gnt_valid,
   output logic [SEL_WIDTH-1:0] gnt_idx
);
   logic [SEL_WIDTH-1:0] idx;
   // Walk the rotation backwards so the closest requester after `last` is the final writer.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = last;
      idx       = '0;
      for (int k = NUM_FIFOS; k >= 1; k--) begin
         idx = SEL_WIDTH'((int'(last) + k) % NUM_FIFOS);
         if (req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = idx;
         end
      end
   end
endmodule

// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: round-robin drain of NUM_FIFOS source FIFOs onto one output stream.
// clk: clock; reset: async active-low; enable: run request; state: FSM state for debug.
// bus (master): fifo_empty/fifo_error/fifo_data/down_almost_full in; fifo_pop/out_data/out_valid/out_sel out.
module fifo_rr_scheduler
   import fifo_rr_scheduler_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int NUM_FIFOS  = NUM_FIFOS_DEF,
   parameter int SEL_WIDTH  = SEL_WIDTH_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   fifo_rr_scheduler_if.master bus,
   output logic [1:0]          state
);
   state_t               state_q, state_d;
   logic [SEL_WIDTH-1:0] last, sel_d, gnt_idx;
   logic                 pop_d, gnt_valid, grant;
   rr_pick #(.NUM_FIFOS(NUM_FIFOS), .SEL_WIDTH(SEL_WIDTH)) u_pick (
      .req       (~bus.fifo_empty),
      .last      (last),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );
   // enable gates the grant too, so a falling enable never leaves a pop behind.
   assign grant = (state_q == ACTIVE) && enable && !bus.down_almost_full && gnt_valid;
   always_comb begin
      state_d = state_q;
      if (|bus.fifo_error) state_d = ERROR;
      else case (state_q)
         IDLE:          state_d = enable ? ACTIVE : IDLE;
         ACTIVE, PAUSE: state_d = !enable ? IDLE : bus.down_almost_full ? PAUSE : ACTIVE;
         default:       state_d = ERROR;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         last    <= SEL_WIDTH'(NUM_FIFOS - 1);
         sel_d   <= '0;
         pop_d   <= 1'b0;
      end else begin
         state_q <= state_d;
         pop_d   <= grant;
         if (grant) begin
            last  <= gnt_idx;
            sel_d <= gnt_idx;
         end
      end
   end
   assign bus.fifo_pop  = grant ? NUM_FIFOS'(1) << gnt_idx : '0;
   assign bus.out_valid = pop_d;
   assign bus.out_sel   = sel_d;
   assign bus.out_data  = pop_d ? bus.fifo_data[sel_d*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign state         = state_q;
endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb_fifo_rr_scheduler: directed self-checking bench with a behavioural source-FIFO bank.
module tb_fifo_rr_scheduler;
   import fifo_rr_scheduler_pkg::*;
   logic       clk = 1'b0, reset = 1'b0, enable = 1'b0, daf = 1'b0, flush = 1'b0;
   logic [3:0] err = 4'b0, empty_v;
   logic [1:0] state;
   logic [9:0] mem [4][32];
   logic [9:0] dout [4] = '{default: '0};
   int         wr [4] = '{default: 0};
   int         rd [4] = '{default: 0};
   int         total = 0, bad = 0;
   fifo_rr_scheduler_if #(.NUM_FIFOS(4), .DATA_WIDTH(10), .SEL_WIDTH(2)) bus ();
   fifo_rr_scheduler #(.DATA_WIDTH(10), .NUM_FIFOS(4), .SEL_WIDTH(2)) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .bus    (bus),
      .state  (state)
   );
   always #5 clk = ~clk;
   // Source FIFO model: data_out registers the head word on read_enable.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (flush) rd[i] <= wr[i];
         else if (bus.fifo_pop[i]) begin
            dout[i] <= mem[i][rd[i]];
            rd[i]   <= rd[i] + 1;
         end
      end
   end
   always_comb begin
      empty_v = '0;
      for (int i = 0; i < 4; i++) empty_v[i] = (rd[i] == wr[i]);
   end
   assign bus.fifo_empty       = empty_v;
   assign bus.fifo_error       = err;
   assign bus.down_almost_full = daf;
   assign bus.fifo_data        = {dout[3], dout[2], dout[1], dout[0]};

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load(input int i, input logic [9:0] w);
      mem[i][wr[i]] = w;
      wr[i]++;
   endtask

   task automatic flush_all();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      enable = 1'b1;
      for (int i = 0; i < 4; i++) load(i, 10'(10'h3F0 + i));
      tick();
      tick();
      total++; if (bus.fifo_pop !== 4'b0) begin bad++; $display("FAIL rst_pop got=%b exp=0000", bus.fifo_pop); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.out_valid); end
      total++; if (state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
      total++; if (bus.out_data !== 10'h0) begin bad++; $display("FAIL rst_data got=%h exp=000", bus.out_data); end
      total++; if (bus.out_sel !== 2'd0) begin bad++; $display("FAIL rst_sel got=%0d exp=0", bus.out_sel); end
      reset = 1'b1;
      tick();
      total++; if (state !== 2'd1) begin bad++; $display("FAIL rst_release_state got=%0d exp=1", state); end
      total++; if (bus.fifo_pop !== 4'b0001) begin bad++; $display("FAIL rst_first_pop got=%b exp=0001", bus.fifo_pop); end
      enable = 1'b0;
      #1;
      total++; if (bus.fifo_pop !== 4'b0) begin bad++; $display("FAIL enable_drop_pop got=%b exp=0000", bus.fifo_pop); end
      tick();
      total++; if (state !== 2'd0) begin bad++; $display("FAIL enable_drop_state got=%0d exp=0", state); end
      flush_all();
   endtask

   task automatic test_fairness();
      logic [9:0] fexp [8] = '{10'h10, 10'h20, 10'h30, 10'h40, 10'h11, 10'h21, 10'h31, 10'h41};
      for (int w = 0; w < 2; w++)
         for (int i = 0; i < 4; i++) load(i, 10'((i + 1) * 16 + w));
      enable = 1'b1;
      tick();
      for (int k = 0; k < 10; k++) begin
         total++; if (bus.fifo_pop !== (k < 8 ? 4'(1 << (k % 4)) : 4'b0)) begin bad++; $display("FAIL fair_pop k=%0d got=%b", k, bus.fifo_pop); end
         total++; if (bus.out_valid !== (k >= 1 && k <= 8)) begin bad++; $display("FAIL fair_valid k=%0d got=%b", k, bus.out_valid); end
         if (k >= 1 && k <= 8) begin
            total++; if (bus.out_data !== fexp[k-1]) begin bad++; $display("FAIL fair_data k=%0d got=%h exp=%h", k, bus.out_data, fexp[k-1]); end
            total++; if (bus.out_sel !== 2'((k - 1) % 4)) begin bad++; $display("FAIL fair_sel k=%0d got=%0d exp=%0d", k, bus.out_sel, (k - 1) % 4); end
         end
         tick();
      end
      enable = 1'b0;
      tick();
   endtask

   task automatic test_skip_empty();
      logic [9:0] sexp [6] = '{10'h51, 10'h71, 10'h52, 10'h72, 10'h53, 10'h73};
      for (int w = 1; w <= 3; w++) begin
         load(1, 10'(10'h50 + w));
         load(3, 10'(10'h70 + w));
      end
      enable = 1'b1;
      tick();
      for (int k = 0; k < 8; k++) begin
         total++; if (bus.fifo_pop !== (k < 6 ? (k % 2 == 0 ? 4'b0010 : 4'b1000) : 4'b0)) begin bad++; $display("FAIL skip_pop k=%0d got=%b", k, bus.fifo_pop); end
         total++; if (bus.out_valid !== (k >= 1 && k <= 6)) begin bad++; $display("FAIL skip_valid k=%0d got=%b", k, bus.out_valid); end
         if (k >= 1 && k <= 6) begin
            total++; if (bus.out_data !== sexp[k-1]) begin bad++; $display("FAIL skip_data k=%0d got=%h exp=%h", k, bus.out_data, sexp[k-1]); end
            total++; if (bus.out_sel !== ((k - 1) % 2 == 0 ? 2'd1 : 2'd3)) begin bad++; $display("FAIL skip_sel k=%0d got=%0d", k, bus.out_sel); end
         end
         tick();
      end
      enable = 1'b0;
      tick();
   endtask

   task automatic test_throttle();
      for (int i = 0; i < 4; i++) load(i, 10'(10'h60 + i));
      enable = 1'b1;
      tick();
      total++; if (bus.fifo_pop !== 4'b0001) begin bad++; $display("FAIL thr_pop0 got=%b exp=0001", bus.fifo_pop); end
      tick();
      daf = 1'b1;
      #1;
      total++; if (bus.fifo_pop !== 4'b0) begin bad++; $display("FAIL thr_suppress got=%b exp=0000", bus.fifo_pop); end
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 10'h60) begin bad++; $display("FAIL thr_inflight valid=%b data=%h exp=1/060", bus.out_valid, bus.out_data); end
      for (int j = 0; j < 2; j++) begin
         tick();
         total++; if (state !== 2'd2) begin bad++; $display("FAIL thr_state j=%0d got=%0d exp=2", j, state); end
         total++; if (bus.out_valid !== 1'b0 || bus.fifo_pop !== 4'b0) begin bad++; $display("FAIL thr_hold j=%0d valid=%b pop=%b exp=0/0000", j, bus.out_valid, bus.fifo_pop); end
      end
      daf = 1'b0;
      #1;
      total++; if (bus.fifo_pop !== 4'b0) begin bad++; $display("FAIL thr_pause_pop got=%b exp=0000", bus.fifo_pop); end
      tick();
      total++; if (state !== 2'd1) begin bad++; $display("FAIL thr_resume_state got=%0d exp=1", state); end
      total++; if (bus.fifo_pop !== 4'b0010) begin bad++; $display("FAIL thr_resume_pop got=%b exp=0010", bus.fifo_pop); end
      for (int j = 1; j <= 4; j++) begin
         tick();
         total++; if (bus.out_valid !== (j <= 3)) begin bad++; $display("FAIL thr_valid j=%0d got=%b", j, bus.out_valid); end
         if (j <= 3) begin
            total++; if (bus.out_data !== 10'(10'h60 + j)) begin bad++; $display("FAIL thr_data j=%0d got=%h exp=%h", j, bus.out_data, 10'h60 + j); end
         end
         total++; if (bus.fifo_pop !== (j < 3 ? 4'(1 << (j + 1)) : 4'b0)) begin bad++; $display("FAIL thr_pop j=%0d got=%b", j, bus.fifo_pop); end
      end
      enable = 1'b0;
      tick();
   endtask

   task automatic test_single_word();
      load(0, 10'h07A);
      enable = 1'b1;
      tick();
      total++; if (bus.fifo_pop !== 4'b0001) begin bad++; $display("FAIL single_pop got=%b exp=0001", bus.fifo_pop); end
      tick();
      total++; if (bus.fifo_pop !== 4'b0) begin bad++; $display("FAIL single_no_second_pop got=%b exp=0000", bus.fifo_pop); end
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 10'h07A) begin bad++; $display("FAIL single_word valid=%b data=%h exp=1/07a", bus.out_valid, bus.out_data); end
      tick();
      total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 10'h0) begin bad++; $display("FAIL single_after valid=%b data=%h exp=0/000", bus.out_valid, bus.out_data); end
      enable = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back_reset();
      load(2, 10'h02A);
      load(2, 10'h02B);
      enable = 1'b1;
      tick();
      total++; if (bus.fifo_pop !== 4'b0100) begin bad++; $display("FAIL b2b_pop0 got=%b exp=0100", bus.fifo_pop); end
      tick();
      total++; if (bus.fifo_pop !== 4'b0100) begin bad++; $display("FAIL b2b_pop1 got=%b exp=0100", bus.fifo_pop); end
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 10'h02A || bus.out_sel !== 2'd2) begin bad++; $display("FAIL b2b_word valid=%b data=%h sel=%0d exp=1/02a/2", bus.out_valid, bus.out_data, bus.out_sel); end
      #2;
      reset = 1'b0;
      #1;
      total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 10'h0 || bus.out_sel !== 2'd0) begin bad++; $display("FAIL async_rst_out valid=%b data=%h sel=%0d exp=0/000/0", bus.out_valid, bus.out_data, bus.out_sel); end
      total++; if (state !== 2'd0 || bus.fifo_pop !== 4'b0) begin bad++; $display("FAIL async_rst_state state=%0d pop=%b exp=0/0000", state, bus.fifo_pop); end
      enable = 1'b0;
      tick();
      reset = 1'b1;
      flush_all();
   endtask

   task automatic test_error();
      enable = 1'b1;
      tick();
      err = 4'b0100;
      tick();
      err = 4'b0;
      load(0, 10'h0E0);
      load(0, 10'h0E1);
      load(1, 10'h0E2);
      #1;
      for (int j = 0; j < 4; j++) begin
         total++; if (state !== 2'd3) begin bad++; $display("FAIL err_state j=%0d got=%0d exp=3", j, state); end
         total++; if (bus.fifo_pop !== 4'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL err_quiet j=%0d pop=%b valid=%b exp=0000/0", j, bus.fifo_pop, bus.out_valid); end
         tick();
      end
      reset = 1'b0;
      #1;
      total++; if (state !== 2'd0) begin bad++; $display("FAIL err_reset got=%0d exp=0", state); end
      enable = 1'b0;
      tick();
      reset = 1'b1;
      flush_all();
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_skip_empty();
      test_throttle();
      test_single_word();
      test_back_to_back_reset();
      test_error();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fifo_rr_scheduler.md
# fifo_rr_scheduler

Round-robin read scheduler that drains `NUM_FIFOS` instances of the team's parameterised FIFO onto one shared output stream. It issues at most one `read_enable` pulse per cycle, picking the next non-empty FIFO after the last one served. It throttles on downstream `almost_full`. It parks in a sticky error state if any FIFO reports `error`. It sits between the per-class FIFO bank and the single downstream FIFO or consumer.

## Interface
- `DATA_WIDTH`, default 10: word width; matches the FIFO `tamano_datos`.
- `NUM_FIFOS`, default 4: number of source FIFOs; fixed at 4 for this revision.
- `SEL_WIDTH`, default 2: width of a FIFO index (clog2 of `NUM_FIFOS`).
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low; low forces all state to reset values immediately.
- `enable`  in  1: high lets the scheduler leave IDLE and keep serving.
- `fifo_empty`  in  `NUM_FIFOS`: bit i is FIFO i's `empty`.
- `fifo_error`  in  `NUM_FIFOS`: bit i is FIFO i's `error`.
- `fifo_data`  in  `NUM_FIFOS*DATA_WIDTH`: FIFO i's `data_out` at bits [i*W +: W].
- `down_almost_full`  in  1: downstream can take at most one more word.
- `fifo_pop`  out  `NUM_FIFOS`: one-hot or zero; bit i drives FIFO i's `read_enable`.
- `out_data`  out  `DATA_WIDTH`: forwarded word; 0 when `out_valid` is low.
- `out_valid`  out  1: `out_data` is a new word this cycle (drives downstream `write_enable`).
- `out_sel`  out  `SEL_WIDTH`: index of the FIFO that `out_data` came from.
- `state`  out  2: current FSM state, for debug.

## Operation
- States:
  - IDLE = 0 (reset state).
  - ACTIVE = 1.
  - PAUSE = 2.
  - ERROR = 3.
- Transitions, evaluated every cycle in priority order:
  - Any `fifo_error` bit high -> ERROR. ERROR is sticky; only `reset` leaves it.
  - IDLE -> ACTIVE when `enable` = 1.
  - ACTIVE -> IDLE when `enable` = 0.
  - ACTIVE -> PAUSE when `down_almost_full` = 1.
  - PAUSE -> ACTIVE when `down_almost_full` = 0 and `enable` = 1.
  - PAUSE -> IDLE when `enable` = 0.
- Grant:
  - Computed only in ACTIVE, and only when `down_almost_full` = 0 in the same cycle.
  - Search order is `last+1`, `last+2`, … mod `NUM_FIFOS`; the first index with `fifo_empty` = 0 wins.
  - If all FIFOs are empty, there is no grant and `last` is unchanged.
- `fifo_pop`:
  - Combinational from the registered state, `last`, `fifo_empty` and `down_almost_full`.
  - At most one bit high.
  - Never asserted for an empty FIFO, and never in IDLE, PAUSE or ERROR.
- On a grant to i, at the clock edge: `last` <= i, `sel_d` <= i, `pop_d` <= 1. Otherwise `pop_d` <= 0.
- Output path:
  - `out_valid` = `pop_d`.
  - `out_sel` = `sel_d`.
  - `out_data` = `pop_d` ? `fifo_data[sel_d]` : 0.
- Reset values:
  - `state` = IDLE, `last` = `NUM_FIFOS`-1 (so the first search starts at FIFO 0).
  - `sel_d` = 0, `pop_d` = 0.
  - Hence `fifo_pop` = 0, `out_valid` = 0, `out_data` = 0, `out_sel` = 0.

## Timing
- Pop-to-data latency is 1 cycle:
  - `fifo_pop[i]` is high in cycle T.
  - FIFO i registers its `data_out` at the end of T.
  - `out_valid` = 1 with that word in T+1.
- Maximum throughput is 1 word per cycle.
- Back-to-back pops to the same FIFO are legal. A FIFO holding one word shows `empty` = 1 in the cycle after its pop and is skipped.
- Throttle: one word can be in flight when `down_almost_full` rises, so sampling `almost_full` (not `full`) keeps the downstream from overflowing. The pop is suppressed in the same cycle `down_almost_full` is seen high.
- Words already popped are always delivered on the next cycle, including across ACTIVE->PAUSE, ACTIVE->IDLE and ->ERROR transitions.
- Reset asserted mid-operation:
  - All outputs go to their reset values immediately, without waiting for a clock.
  - An in-flight word is dropped.
  - The source FIFOs reset on their own.
- `enable` dropping in cycle T: no pop in T, and the FSM is IDLE in T+1.

## Structure
- Shared package holds:
  - The state encodings IDLE/ACTIVE/PAUSE/ERROR.
  - `NUM_FIFOS` and `DATA_WIDTH` defaults, shared with the FIFO bank top level.
- One sub-module, `rr_pick`: purely combinational. Takes `req[NUM_FIFOS]` and `last`, returns `gnt_valid` and `gnt_idx`. It is reused by the future downstream arbiter.
- The FSM, the `last`/`sel_d`/`pop_d` registers and the output mux stay in `fifo_rr_scheduler`.

## Test plan
- Reset: hold `reset` = 0 with all `fifo_empty` = 0 and `enable` = 1 -> `fifo_pop` = 0, `out_valid` = 0, `state` = 0. Release `reset` -> `state` = 1 on the next edge.
- Fairness: FIFOs 0..3 preloaded with 2 words each (0x10,0x11 / 0x20,0x21 / 0x30,0x31 / 0x40,0x41) -> `out_data` sequence is 0x10,0x20,0x30,0x40,0x11,0x21,0x31,0x41 on 8 consecutive cycles, with `out_sel` 0,1,2,3,0,1,2,3.
- Skip empty: only FIFOs 1 and 3 non-empty, `last` = 3 -> pops go 1,3,1,3…, and `fifo_pop[0]` and `fifo_pop[2]` never rise.
- Throttle: raise `down_almost_full` while streaming -> no pop in that cycle; exactly one more `out_valid` (the in-flight word); `state` = 2. Drop it -> the pop resumes at the next index in rotation with no word lost or duplicated.
- Error: pulse `fifo_error[2]` = 1 for one cycle -> `state` = 3 from the next cycle onward and `fifo_pop` = 0 until `reset` is asserted, even after `fifo_error` returns to 0.
- Single-word drain: FIFO 0 holds 1 word, others empty -> one pop, then `fifo_empty[0]` = 1 and no second pop; `out_valid` is high for exactly one cycle.
